// File: rtl/hamming_rx_controller.sv
// Serial Hamming(7,4) receive sequencer: assembles 7-bit frames, decodes them, hands data out on valid/ready.
// Define HAMMING_ERR_COUNT_EN to compile in CNT_W and the saturating err_count port.
module hamming_rx_controller
`ifdef HAMMING_ERR_COUNT_EN
  #(parameter int CNT_W = 8)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             clear
`ifdef HAMMING_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Syndrome bit k is the parity over the positions whose index has bit k set.
  function automatic logic [2:0] hamming_syndrome(input logic [6:0] v);
    hamming_syndrome = {v[3] ^ v[4] ^ v[5] ^ v[6],
                        v[1] ^ v[2] ^ v[5] ^ v[6],
                        v[0] ^ v[2] ^ v[4] ^ v[6]};
  endfunction

  function automatic logic [3:0] hamming_data(input logic [6:0] v, input logic [2:0] s);
    logic [7:0] mask;
    logic [6:0] fixed;
    mask  = 8'd1 << s;
    fixed = v ^ mask[7:1];
    hamming_data = {fixed[6], fixed[5], fixed[4], fixed[2]};
  endfunction

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] sr_q, sr_d;
  logic [6:0] cw_q, cw_d;
  logic [3:0] out_data_q, out_data_d;
  logic [2:0] out_syndrome_q, out_syndrome_d;
  logic       out_corrected_q, out_corrected_d;
  logic       out_valid_q, out_valid_d;
  logic       overflow_q, overflow_d;
  logic       complete_s, hs_s, drop_s;
  logic [3:0] dec_w_s;
  logic [2:0] dec_s_s;

  assign dec_s_s    = hamming_syndrome(cw_q);
  assign dec_w_s    = hamming_data(cw_q, dec_s_s);
  assign complete_s = bit_valid && (bit_cnt_q == 3'd6);
  assign hs_s       = (state_q == ST_PRESENT) && out_ready;

  // Next-state logic: bit assembly, FSM, drop detection and overflow flag.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    sr_d            = sr_q;
    cw_d            = cw_q;
    out_data_d      = out_data_q;
    out_syndrome_d  = out_syndrome_q;
    out_corrected_d = out_corrected_q;
    out_valid_d     = out_valid_q;
    drop_s          = 1'b0;

    if (bit_valid) begin
      sr_d[bit_cnt_q] = bit_in;
      bit_cnt_d       = (bit_cnt_q == 3'd6) ? 3'd0 : bit_cnt_q + 3'd1;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (complete_s) begin
          cw_d    = sr_d;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        out_data_d      = dec_w_s;
        out_syndrome_d  = dec_s_s;
        out_corrected_d = (dec_s_s != 3'd0);
        out_valid_d     = 1'b1;
        state_d         = ST_PRESENT;
        drop_s          = complete_s;
      end
      ST_PRESENT: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          if (complete_s) begin
            cw_d    = sr_d;
            state_d = ST_DECODE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          drop_s = complete_s;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // A drop on the same edge as clear must leave the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= 3'd0;
      sr_q            <= 7'd0;
      cw_q            <= 7'd0;
      out_data_q      <= 4'd0;
      out_syndrome_q  <= 3'd0;
      out_corrected_q <= 1'b0;
      out_valid_q     <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      sr_q            <= sr_d;
      cw_q            <= cw_d;
      out_data_q      <= out_data_d;
      out_syndrome_q  <= out_syndrome_d;
      out_corrected_q <= out_corrected_d;
      out_valid_q     <= out_valid_d;
      overflow_q      <= overflow_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_syndrome  = out_syndrome_q;
  assign out_corrected = out_corrected_q;
  assign out_valid     = out_valid_q;
  assign overflow      = overflow_q;

`ifdef HAMMING_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Saturating corrected-word counter; clear beats a same-edge increment.
  always_comb begin
    if (clear) begin
      err_count_d = {CNT_W{1'b0}};
    end else if (hs_s && out_corrected_q && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_hamming_rx_controller.sv
// Scoreboard bench for hamming_rx_controller: event-level reference model feeds an expectation queue,
// a negedge monitor compares every presented word and the per-cycle status outputs.
module tb_hamming_rx_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_corrected;
  logic       out_valid;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

`ifdef HAMMING_ERR_COUNT_EN
  localparam int TB_CNT_W = 2;
  logic [TB_CNT_W-1:0] err_count;
  hamming_rx_controller #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .clear(clear),
    .err_count(err_count));
`else
  hamming_rx_controller dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .clear(clear));
`endif

  always #5 clk = ~clk;

  // Reference decode: syndrome is the XOR of the 1-based positions holding a 1.
  function automatic logic [7:0] ref_decode(input logic [6:0] w);
    int syn;
    logic [6:0] c;
    syn = 0;
    for (int p = 1; p <= 7; p++) if (w[p-1]) syn = syn ^ p;
    c = w;
    if (syn != 0) c[syn-1] = ~c[syn-1];
    return {(syn != 0), 3'(syn), c[6], c[5], c[4], c[2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0] exp_q[$];
  bit         m_busy = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_corr = 1'b0;
  int         m_cnt = 0;
  int         m_pos = 0;
  logic [6:0] m_word = 7'd0;

  // Reference model: advances on each rising edge from the inputs the bench drove.
  initial begin
    forever begin
      bit complete, hs, accept, drop;
      logic [7:0] r;
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_valid = 0; m_ovf = 0; m_cnt = 0; m_pos = 0; m_corr = 0;
        m_word = 7'd0;
        exp_q.delete();
      end else begin
        complete = 0;
        hs = m_valid && out_ready;
        if (bit_valid) begin
          m_word[m_pos] = bit_in;
          complete = (m_pos == 6);
          m_pos = complete ? 0 : m_pos + 1;
        end
        accept = complete && (!m_busy || hs);
        drop   = complete && !accept;
`ifdef HAMMING_ERR_COUNT_EN
        if (clear) m_cnt = 0;
        else if (hs && m_corr && m_cnt < (1 << TB_CNT_W) - 1) m_cnt = m_cnt + 1;
`endif
        if (hs) begin
          m_busy = 0; m_valid = 0;
        end else if (m_busy) begin
          m_valid = 1;
        end
        if (accept) begin
          r = ref_decode(m_word);
          exp_q.push_back(r);
          m_corr = r[7];
          m_busy = 1; m_valid = 0;
        end
        if (drop) m_ovf = 1;
        else if (clear) m_ovf = 0;
      end
    end
  end

  // Monitor: status every cycle, stability while held, and scoreboard pop on handshake.
  initial begin
    bit         prev_valid = 0;
    bit         prev_hs = 0;
    logic [7:0] prev_bus = 8'd0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef HAMMING_ERR_COUNT_EN
        check("err_count", 32'(err_count), 32'(m_cnt));
`endif
        if (out_valid && prev_valid && !prev_hs)
          check("held_stable", 32'({out_corrected, out_syndrome, out_data}), 32'(prev_bus));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'({out_corrected, out_syndrome, out_data}), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[3:0]));
            check("out_syndrome", 32'(out_syndrome), 32'(e[6:4]));
            check("out_corrected", 32'(out_corrected), 32'(e[7]));
          end
        end
        prev_valid = out_valid;
        prev_hs    = out_valid && out_ready;
        prev_bus   = {out_corrected, out_syndrome, out_data};
      end else begin
        prev_valid = 0;
      end
    end
  end

  task automatic drive(input logic bv, input logic b, input logic rdy, input logic clr);
    bit_valid = bv; bit_in = b; out_ready = rdy; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [6:0] w, input logic rdy);
    for (int i = 0; i < 7; i++) drive(1'b1, w[i], rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    check("rst_out_corrected", 32'(out_corrected), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef HAMMING_ERR_COUNT_EN
    check("rst_err_count", 32'(err_count), 32'd0);
`endif
    mon_en = 1'b1;
  endtask

  initial begin
    logic [6:0] wa, wb;
    do_reset();

    // Clean word: valid two edges after the seventh bit.
    send_word(7'b1010101, 1'b1);
    check("clean_latency_e", 32'(out_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("clean_valid", 32'(out_valid), 32'd1);
    check("clean_data", 32'(out_data), 32'b1011);
    check("clean_syn", 32'(out_syndrome), 32'd0);
    check("clean_corr", 32'(out_corrected), 32'd0);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Position 5 flipped.
    send_word(7'b1000101, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("err_data", 32'(out_data), 32'b1011);
    check("err_syn", 32'(out_syndrome), 32'd5);
    check("err_corr", 32'(out_corrected), 32'd1);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: second word is dropped, first one held.
    wa = 7'b0110011;
    wb = 7'b1111000;
    send_word(wa, 1'b0);
    send_word(wb, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_held_data", 32'(out_data), 32'(ref_decode(wa) & 8'h0F));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_idle_after_hs", 32'(out_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_clear", 32'(overflow), 32'd0);

    // Same-edge handshake and completion.
    send_word(7'b0001111, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, wb[i], 1'b0, 1'b0);
    drive(1'b1, wb[6], 1'b1, 1'b0);
    check("same_edge_decode", 32'(out_valid), 32'd0);
    check("same_edge_no_ovf", 32'(overflow), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("same_edge_present", 32'(out_valid), 32'd1);
    check("same_edge_data", 32'(out_data), 32'(ref_decode(wb) & 8'h0F));
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame discards the partial bits.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    send_word(7'b1010101, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_data", 32'(out_data), 32'b1011);
    check("post_rst_syn", 32'(out_syndrome), 32'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef HAMMING_ERR_COUNT_EN
    // Saturation at 3 for a 2-bit counter, then clear against an increment.
    for (int k = 1; k <= 5; k++) begin
      send_word(7'b1000101, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0);
      check("sat_count", 32'(err_count), 32'((k > 3) ? 3 : k));
    end
    send_word(7'b1000101, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("clear_beats_inc", 32'(err_count), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomised traffic against the model.
    repeat (600) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    repeat (12) drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
